one_hot_scan_decoder: RTL and testbench
=======================================

Name: one_hot_scan_decoder

Overview:
Parametrised, registered binary-to-one-hot decoder with two modes.
- Direct mode: decodes an index accepted over a valid/ready handshake.
- Scan mode: steps a single active output through every position with a programmable dwell time, and flags the end of each full sweep.
- Drives row/column select lines into the cell array and display path, replacing fixed-width combinational decoders wherever a select must be held or swept.

Parameters:
- SEL_WIDTH, 2, width of the binary index. NUM_OUT = 2**SEL_WIDTH is derived locally and is not overridable.
- DWELL_WIDTH, 8, width of the DWELL input and of the internal dwell counter.

Ports:
- CLK  input  1  single clock, rising edge
- RST  input  1  asynchronous, active-high reset
- EN  input  1  block enable. 0 forces outputs idle.
- MODE  input  1  0 = direct, 1 = scan
- SEL_IN  input  SEL_WIDTH  index to decode in direct mode
- SEL_VALID  input  1  SEL_IN is valid
- SEL_READY  output  1  block accepts SEL_IN this cycle
- DWELL  input  DWELL_WIDTH  cycles each index is held in scan mode
- ONE_HOT_OUT  output  NUM_OUT  one-hot (or all-zero) select
- IDX_OUT  output  SEL_WIDTH  binary index of the asserted bit (0 when idle)
- BUSY  output  1  1 while in SCAN state
- FRAME_DONE  output  1  one-cycle pulse on the final cycle of each sweep

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset values (immediately on RST=1, held while RST=1): ONE_HOT_OUT=0, IDX_OUT=0, BUSY=0, FRAME_DONE=0, SEL_READY=0, state=IDLE, dwell counter=0.
- States: IDLE, HOLD, SCAN. All outputs except SEL_READY are registered.
- SEL_READY = EN & ~MODE & (state != SCAN) & ~RST. This is combinational from registered state and inputs.
- Accept: SEL_VALID & SEL_READY at a rising edge.
- IDLE:
  - accept → HOLD; next cycle ONE_HOT_OUT = 1<<SEL_IN and IDX_OUT = SEL_IN (1-cycle latency).
  - EN & MODE → SCAN at index 0.
  - otherwise stay; outputs 0.
- HOLD:
  - outputs held until the next event.
  - new accept → replace the decoded value next cycle. Back-to-back accepts update every cycle.
  - EN=0 → IDLE, outputs 0 next cycle.
  - EN & MODE → SCAN at index 0 next cycle.
- SCAN entry: IDX_OUT=0, ONE_HOT_OUT=1, BUSY=1, dwell counter loaded with eff_dwell-1.
  - eff_dwell = (DWELL==0) ? 1 : DWELL.
  - DWELL is sampled at the start of every index step. Mid-step changes affect the next step only.
- SCAN step: the counter decrements each cycle. On the cycle it reads 0, the next edge does both:
  - advances IDX_OUT by 1, wrapping NUM_OUT-1 → 0;
  - reloads the counter.
  - Each index is therefore active for exactly eff_dwell cycles.
  - Scan runs continuously with no gap cycle at wrap.
- FRAME_DONE: 1 exactly for the cycle where IDX_OUT == NUM_OUT-1 and the counter reads 0. Registered, aligned with ONE_HOT_OUT.
- SCAN exit: EN=0 or MODE=0 at an edge → IDLE next cycle with outputs 0 and BUSY=0.
  - The partial frame is abandoned; FRAME_DONE is not asserted for it.
  - If exit coincides with the final cycle of a frame, the FRAME_DONE already showing that cycle stands.
- SEL_VALID while MODE=1 or EN=0 is ignored (SEL_READY=0). No data is queued.
- Invariant: ONE_HOT_OUT is always zero or has exactly one bit set, and that bit equals IDX_OUT.
- Reset asserted mid-scan or mid-hold clears everything asynchronously.
  - After RST deasserts, the first edge behaves as from IDLE.
  - If EN & MODE are already high, scan begins at index 0 on that first edge.

Decomposition:
- Shared package decoder_pkg:
  - state enum typedef (IDLE, HOLD, SCAN);
  - MODE_DIRECT=1'b0, MODE_SCAN=1'b1 constants.
- One sub-module, dwell_timer:
  - DWELL_WIDTH-bit down-counter with load, clear and terminal-count output;
  - instantiated once.

Test Plan (SEL_WIDTH=2 unless stated):
- Reset/idle: RST pulse mid-cycle → all outputs 0 immediately. After release with EN=0 → SEL_READY=0, ONE_HOT_OUT=0.
- Direct decode: EN=1, MODE=0; accept SEL_IN=2, then 0, 3, 1 on consecutive cycles → ONE_HOT_OUT = 0100, 0001, 1000, 0010, one cycle after each accept. Then drop EN → 0000 next cycle.
- Scan dwell: MODE=1, DWELL=3 → indices 0,1,2,3 each held 3 cycles; FRAME_DONE high once per 12 cycles, on cycle 12. Wrap to 0001 with no gap. DWELL=0 → each index held 1 cycle, FRAME_DONE every 4 cycles.
- Mode switches:
  - MODE 1→0 at index 2 → 0000 next cycle, no FRAME_DONE, SEL_READY=1.
  - From HOLD at index 3, MODE 0→1 → scan starts at 0001.
  - SEL_VALID during scan → no effect.
- Reset mid-scan: RST at index 1 → immediate clear. Release with EN=MODE=1 → index 0 on the first edge, full dwell.
- Width sweep: SEL_WIDTH=4, DWELL_WIDTH=3, DWELL=7 → 16 indices × 7 cycles; FRAME_DONE every 112 cycles. Invariant (ONE_HOT_OUT zero or one-hot, set bit equals IDX_OUT) checked every cycle.

Source files
------------

// File: rtl/one_hot_scan_decoder_pkg.sv
// Shared types for the one-hot scan decoder: controller states and mode encodings.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/one_hot_scan_decoder_dwell_timer.sv
// Dwell down-counter: clear beats load, otherwise counts down and parks at zero.
module dwell_timer #(
    parameter int DWELL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   clear,
    input  logic [DWELL_WIDTH-1:0] load_val,
    output logic [DWELL_WIDTH-1:0] count,
    output logic                   tc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/one_hot_scan_decoder.sv
// Registered binary-to-one-hot decoder with a direct (handshake) mode and a dwell-timed scan mode.
//   state | meaning
//   IDLE  | outputs zero, waiting for an accept or scan request
//   HOLD  | last accepted index decoded and held
//   SCAN  | single active bit stepping through every position
module one_hot_scan_decoder
    import decoder_pkg::*;
#(
    parameter int SEL_WIDTH   = 2,
    parameter int DWELL_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic                      MODE,
    input  logic [SEL_WIDTH-1:0]      SEL_IN,
    input  logic                      SEL_VALID,
    output logic                      SEL_READY,
    input  logic [DWELL_WIDTH-1:0]    DWELL,
    output logic [(2**SEL_WIDTH)-1:0] ONE_HOT_OUT,
    output logic [SEL_WIDTH-1:0]      IDX_OUT,
    output logic                      BUSY,
    output logic                      FRAME_DONE
);

    localparam int NUM_OUT = 2**SEL_WIDTH;
    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_OUT - 1);

    state_t                   state_q;
    logic [SEL_WIDTH-1:0]     idx_q;
    logic [NUM_OUT-1:0]       one_hot_q;
    logic                     busy_q;
    logic                     frame_done_q;

    logic [DWELL_WIDTH-1:0]   count;
    logic                     tc;
    logic                     timer_load;
    logic                     timer_clear;
    logic [DWELL_WIDTH-1:0]   eff_dwell_m1;
    logic                     scan_go;
    logic                     accept;
    logic [SEL_WIDTH-1:0]     idx_step;

    function automatic logic [NUM_OUT-1:0] decode(input logic [SEL_WIDTH-1:0] idx);
        logic [NUM_OUT-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // A programmed dwell of zero still holds each index for one cycle.
    assign eff_dwell_m1 = (DWELL == '0) ? '0 : DWELL - 1'b1;
    assign scan_go      = EN & (MODE == MODE_SCAN);
    assign SEL_READY    = EN & (MODE == MODE_DIRECT) & (state_q != SCAN) & ~RST;
    assign accept       = SEL_VALID & SEL_READY;
    assign idx_step     = idx_q + 1'b1;

    assign timer_load  = scan_go & ((state_q != SCAN) | tc);
    assign timer_clear = (state_q == SCAN) & ~scan_go;

    dwell_timer #(
        .DWELL_WIDTH(DWELL_WIDTH)
    ) u_dwell_timer (
        .clk     (CLK),
        .rst     (RST),
        .load    (timer_load),
        .clear   (timer_clear),
        .load_val(eff_dwell_m1),
        .count   (count),
        .tc      (tc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            one_hot_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (!scan_go) begin
                        state_q   <= IDLE;
                        idx_q     <= '0;
                        one_hot_q <= '0;
                        busy_q    <= 1'b0;
                    end else if (tc) begin
                        idx_q        <= idx_step;
                        one_hot_q    <= decode(idx_step);
                        frame_done_q <= (idx_step == LAST_IDX) && (eff_dwell_m1 == '0);
                    end else begin
                        // Counter reads 1 now, so next cycle is the last of this index.
                        frame_done_q <= (idx_q == LAST_IDX) && (count == DWELL_WIDTH'(1));
                    end
                end
                default: begin
                    if (scan_go) begin
                        state_q   <= SCAN;
                        idx_q     <= '0;
                        one_hot_q <= NUM_OUT'(1);
                        busy_q    <= 1'b1;
                    end else if (!EN) begin
                        state_q   <= IDLE;
                        idx_q     <= '0;
                        one_hot_q <= '0;
                    end else if (accept) begin
                        state_q   <= HOLD;
                        idx_q     <= SEL_IN;
                        one_hot_q <= decode(SEL_IN);
                    end
                end
            endcase
        end
    end

    assign ONE_HOT_OUT = one_hot_q;
    assign IDX_OUT     = idx_q;
    assign BUSY        = busy_q;
    assign FRAME_DONE  = frame_done_q;

endmodule

// File: tb/tb_one_hot_scan_decoder.sv
// Bench for one_hot_scan_decoder: vector table, scan sequences, random run against a model, wide sweep.
module tb_one_hot_scan_decoder;

    logic       CLK = 1'b0;
    logic       RST;
    logic       en, mode, valid;
    logic [1:0] sel;
    logic [7:0] dwell;
    logic       ready, busy, fd;
    logic [3:0] oh;
    logic [1:0] idx;

    logic        w_en, w_mode, w_valid, w_ready, w_busy, w_fd;
    logic [3:0]  w_sel, w_idx;
    logic [2:0]  w_dwell;
    logic [15:0] w_oh;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    one_hot_scan_decoder #(.SEL_WIDTH(2), .DWELL_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .EN(en), .MODE(mode), .SEL_IN(sel), .SEL_VALID(valid),
        .SEL_READY(ready), .DWELL(dwell), .ONE_HOT_OUT(oh), .IDX_OUT(idx), .BUSY(busy),
        .FRAME_DONE(fd)
    );

    one_hot_scan_decoder #(.SEL_WIDTH(4), .DWELL_WIDTH(3)) dut_wide (
        .CLK(CLK), .RST(RST), .EN(w_en), .MODE(w_mode), .SEL_IN(w_sel), .SEL_VALID(w_valid),
        .SEL_READY(w_ready), .DWELL(w_dwell), .ONE_HOT_OUT(w_oh), .IDX_OUT(w_idx), .BUSY(w_busy),
        .FRAME_DONE(w_fd)
    );

    // Reference model: which index is lit and how many cycles it has left to stay lit.
    typedef struct {
        bit scanning;
        bit active;
        int idx;
        int left;
        bit fd;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(mstate_t cur, bit e, bit md, bit v, int s, int d);
        mstate_t n;
        int eff;
        n   = cur;
        eff = (d == 0) ? 1 : d;
        n.fd = 1'b0;
        if (cur.scanning) begin
            if (!e || !md) begin
                n.scanning = 1'b0; n.active = 1'b0; n.idx = 0; n.left = 0;
            end else if (cur.left == 1) begin
                n.idx  = (cur.idx + 1) % 4;
                n.left = eff;
            end else begin
                n.left = cur.left - 1;
            end
            if (n.scanning) n.fd = (n.idx == 3) && (n.left == 1);
        end else if (e && md) begin
            n.scanning = 1'b1; n.active = 1'b1; n.idx = 0; n.left = eff;
        end else if (!e) begin
            n.active = 1'b0; n.idx = 0;
        end else if (v) begin
            n.active = 1'b1; n.idx = s;
        end
        return n;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) m <= '{scanning: 1'b0, active: 1'b0, idx: 0, left: 0, fd: 1'b0};
        else     m <= model_next(m, en, mode, valid, int'(sel), int'(dwell));
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_model(input int cyc);
        int exp_oh;
        exp_oh = m.active ? (1 << m.idx) : 0;
        check($sformatf("rnd%0d_oh", cyc), int'(oh), exp_oh);
        check($sformatf("rnd%0d_idx", cyc), int'(idx), m.active ? m.idx : 0);
        check($sformatf("rnd%0d_busy", cyc), int'(busy), int'(m.scanning));
        check($sformatf("rnd%0d_fd", cyc), int'(fd), int'(m.fd));
        check($sformatf("rnd%0d_ready", cyc), int'(ready), int'(en && !mode && !m.scanning));
    endtask

    typedef struct {
        bit en; bit mode; bit valid; int sel; int dwell;
        int exp_oh; int exp_idx; int exp_busy; int exp_fd;
    } vec_t;

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{0, 0, 1, 2, 0,  0, 0, 0, 0};
        vecs[1]  = '{1, 0, 1, 2, 0,  4, 2, 0, 0};
        vecs[2]  = '{1, 0, 1, 0, 0,  1, 0, 0, 0};
        vecs[3]  = '{1, 0, 1, 3, 0,  8, 3, 0, 0};
        vecs[4]  = '{1, 0, 1, 1, 0,  2, 1, 0, 0};
        vecs[5]  = '{1, 0, 0, 3, 0,  2, 1, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0};
        vecs[7]  = '{1, 1, 1, 3, 1,  1, 0, 1, 0};
        vecs[8]  = '{1, 1, 1, 3, 1,  2, 1, 1, 0};
        vecs[9]  = '{1, 1, 0, 0, 1,  4, 2, 1, 0};
        vecs[10] = '{1, 1, 0, 0, 1,  8, 3, 1, 1};
        vecs[11] = '{1, 1, 0, 0, 1,  1, 0, 1, 0};
        vecs[12] = '{1, 0, 0, 0, 1,  0, 0, 0, 0};
        vecs[13] = '{1, 0, 1, 3, 1,  8, 3, 0, 0};
        vecs[14] = '{1, 1, 0, 0, 2,  1, 0, 1, 0};
        vecs[15] = '{1, 1, 0, 0, 2,  1, 0, 1, 0};
        vecs[16] = '{1, 1, 0, 0, 2,  2, 1, 1, 0};

        RST = 1'b1; en = 1'b1; mode = 1'b0; valid = 1'b0; sel = '0; dwell = '0;
        w_en = 1'b0; w_mode = 1'b0; w_valid = 1'b0; w_sel = '0; w_dwell = 3'd7;
        repeat (2) tick();
        check("rst_oh", int'(oh), 0);
        check("rst_idx", int'(idx), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fd", int'(fd), 0);
        check("rst_ready", int'(ready), 0);
        en = 1'b0;
        RST = 1'b0;
        tick();
        check("idle_ready_en0", int'(ready), 0);
        check("idle_oh_en0", int'(oh), 0);

        foreach (vecs[i]) begin
            en = vecs[i].en; mode = vecs[i].mode; valid = vecs[i].valid;
            sel = 2'(vecs[i].sel); dwell = 8'(vecs[i].dwell);
            tick();
            check($sformatf("vec%0d_oh", i), int'(oh), vecs[i].exp_oh);
            check($sformatf("vec%0d_idx", i), int'(idx), vecs[i].exp_idx);
            check($sformatf("vec%0d_busy", i), int'(busy), vecs[i].exp_busy);
            check($sformatf("vec%0d_fd", i), int'(fd), vecs[i].exp_fd);
        end

        // DWELL=3 sweep with SEL_VALID asserted throughout; the handshake must stay closed.
        en = 1'b0; valid = 1'b0; tick();
        en = 1'b1; mode = 1'b1; dwell = 8'd3; valid = 1'b1; sel = 2'd3;
        for (int t = 0; t < 24; t++) begin
            tick();
            check($sformatf("d3_t%0d_idx", t), int'(idx), (t / 3) % 4);
            check($sformatf("d3_t%0d_oh", t), int'(oh), 1 << ((t / 3) % 4));
            check($sformatf("d3_t%0d_fd", t), int'(fd), int'(t % 12 == 11));
            check($sformatf("d3_t%0d_ready", t), int'(ready), 0);
        end
        valid = 1'b0;

        en = 1'b0; tick();
        en = 1'b1; dwell = 8'd0;
        for (int t = 0; t < 8; t++) begin
            tick();
            check($sformatf("d0_t%0d_idx", t), int'(idx), t % 4);
            check($sformatf("d0_t%0d_fd", t), int'(fd), int'(t % 4 == 3));
        end

        // Leave scan while index 2 is lit.
        en = 1'b0; tick();
        en = 1'b1; dwell = 8'd3;
        repeat (7) tick();
        check("sw_pre_idx", int'(idx), 2);
        mode = 1'b0;
        tick();
        check("sw_oh", int'(oh), 0);
        check("sw_fd", int'(fd), 0);
        check("sw_busy", int'(busy), 0);
        check("sw_ready", int'(ready), 1);

        // Asynchronous reset while index 1 is lit, released with scan still requested.
        mode = 1'b1; tick();
        repeat (3) tick();
        check("rs_pre_idx", int'(idx), 1);
        #2 RST = 1'b1;
        #1;
        check("rs_oh", int'(oh), 0);
        check("rs_idx", int'(idx), 0);
        check("rs_busy", int'(busy), 0);
        @(negedge CLK);
        RST = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            check($sformatf("rs_t%0d_idx", t), int'(idx), t / 3);
            check($sformatf("rs_t%0d_busy", t), int'(busy), 1);
        end

        for (int c = 0; c < 400; c++) begin
            en    = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            valid = 1'($urandom);
            sel   = 2'($urandom);
            dwell = 8'($urandom_range(0, 3));
            tick();
            check_model(c);
            check($sformatf("rnd%0d_inv", c), int'(oh == 4'd0 || oh == (4'd1 << idx)), 1);
        end

        w_en = 1'b1; w_mode = 1'b1; w_dwell = 3'd7;
        for (int t = 0; t < 240; t++) begin
            tick();
            check($sformatf("w_t%0d_idx", t), int'(w_idx), (t / 7) % 16);
            check($sformatf("w_t%0d_oh", t), int'(w_oh), 1 << ((t / 7) % 16));
            check($sformatf("w_t%0d_fd", t), int'(w_fd), int'(t % 112 == 111));
            check($sformatf("w_t%0d_inv", t), int'(w_oh == 16'd0 || w_oh == (16'd1 << w_idx)), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
